usb_txn_ctrl: RTL and testbench
===============================

USB_TXN_CTRL -- requirements
Module: usb_txn_ctrl

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 8, meaning the number of attempts before a transaction fails.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the response-wait limit in clk cycles (8-bit counter).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_L, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: transaction request, sampled only in IDLE.
REQ-006 SHALL have port is_in, input, 1 bit: 1 selects an IN (read) transaction, 0 selects an OUT (write) transaction; captured with start.
REQ-007 SHALL have ports txn_addr (input, 7 bits), txn_endp (input, 4 bits) and wdata (input, 64 bits): target and write payload; captured with start.
REQ-008 SHALL have ports done (output, 1 bit), success (output, 1 bit) and rdata (output, 64 bits): completion pulse, completion status and read payload.
REQ-009 SHALL have ports pid, endp (output, 4 bits each), addr (output, 7 bits), data (output, 64 bits), pkttype (output, 1 bit) and pktready_bs (output, 1 bit): the drive to the output pipe.
REQ-010 SHALL have ports down_ready and sending_usb (input, 1 bit each): status from the output pipe.
REQ-011 SHALL have ports in_data (input, 64 bits) and in_pktready, in_error, in_ack, in_nak, inpipe_recving (input, 1 bit each): status from the input pipe.

Function
REQ-012 SHALL use the PID encodings OUT=0001, IN=1001, DATA0=0011, ACK=0010 and NAK=1010.
REQ-013 SHALL set pkttype=0 for token packets and pkttype=1 for data and handshake packets.
REQ-014 SHALL implement states IDLE, SEND_TOK, SEND_DATA, WAIT_HS, WAIT_DATA, SEND_ACK, SEND_NAK and FINISH.
REQ-015 SHALL, in IDLE with start=1, capture the request, clear the retry count and go to SEND_TOK.
REQ-016 SHALL launch each packet by pulsing pktready_bs for exactly one cycle, only while down_ready=1.
REQ-017 SHALL hold pid, addr, endp, data and pkttype stable from launch until sending_usb falls, which marks packet complete.
REQ-018 SHALL, in SEND_TOK, send pid OUT or IN per is_in; on completion go to SEND_DATA for OUT or WAIT_DATA for IN.
REQ-019 SHALL, in SEND_DATA, send DATA0 with data=wdata; on completion go to WAIT_HS.
REQ-020 SHALL, in WAIT_HS, treat in_ack as success and go to FINISH; in_nak or in_error SHALL count as a failed attempt.
REQ-021 SHALL, in WAIT_DATA, on in_pktready with in_error=0, latch rdata<=in_data and go to SEND_ACK.
REQ-022 SHALL, in WAIT_DATA, treat in_error as a failed attempt and go to SEND_NAK; in_nak SHALL count as a failed attempt.
REQ-023 SHALL, in SEND_ACK, go to FINISH with success on completion.
REQ-024 SHALL, in SEND_NAK, apply the failed-attempt rule on completion.
REQ-025 SHALL, on a failed attempt, increment the retry count; at count=MAX_RETRY it SHALL go to FINISH with failure, else to SEND_TOK.
REQ-026 SHALL, in FINISH, pulse done for one cycle with success valid in that cycle, then return to IDLE.
REQ-027 SHALL ignore start outside IDLE.
REQ-028 SHALL change rdata only on a successful IN transaction.
REQ-029 SHALL, when in_ack and in_nak are asserted in the same cycle, give in_nak priority.
REQ-030 SHALL not evaluate a response while inpipe_recving=1 unless in_pktready, in_ack or in_nak is also asserted that cycle.

Reset
REQ-031 SHALL, with rst_L=0 (including mid-packet), force state IDLE and clear the retry and timeout counters.
REQ-032 SHALL, during reset, drive done=0, success=0, pktready_bs=0 and rdata=0.
REQ-033 SHALL, during reset, drive pid=0, addr=0, endp=0, data=0 and pkttype=0.
REQ-034 SHALL, after rst_L rises, accept start no earlier than the next rising edge.

Configuration
REQ-035 SHALL, with USB_TXN_TIMEOUT_EN defined, count cycles in WAIT_HS and WAIT_DATA and treat reaching TIMEOUT with no response as a failed attempt.
REQ-036 SHALL, with USB_TXN_TIMEOUT_EN undefined, omit the timeout counter and wait indefinitely in WAIT_HS and WAIT_DATA.

Verification
REQ-037 SHALL cover a successful OUT: start, is_in=0, addr=0x05, endp=0x2, wdata=0xDEADBEEFCAFEF00D, pipe returns in_ack -> packets OUT then DATA0 are launched, then done=1, success=1.
REQ-038 SHALL cover a successful IN: is_in=1, pipe returns in_pktready with in_data=0x0123456789ABCDEF -> an ACK packet is sent, rdata=0x0123456789ABCDEF, done=1, success=1.
REQ-039 SHALL cover retry exhaustion: OUT answered by in_nak 8 times -> 8 OUT+DATA0 pairs are sent, then done=1, success=0.
REQ-040 SHALL cover an IN error: first IN answered by in_error, second by good data -> NAK sent, IN token resent, then success=1.
REQ-041 SHALL cover timeout: with USB_TXN_TIMEOUT_EN defined and no response -> retry after 255 cycles; with it undefined -> remains in WAIT_HS.
REQ-042 SHALL cover reset mid-packet: rst_L=0 while sending_usb=1 -> all outputs 0, state IDLE; a new start afterward completes normally.

Source files
------------

// File: rtl/usb_txn_ctrl.sv
// USB host transaction sequencer: token / data / handshake packets with bounded retries.
// Define USB_TXN_TIMEOUT_EN to add a response timeout in WAIT_HS and WAIT_DATA.
module usb_txn_ctrl #(
    parameter int MAX_RETRY = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        start,
    input  logic        is_in,
    input  logic [6:0]  txn_addr,
    input  logic [3:0]  txn_endp,
    input  logic [63:0] wdata,
    output logic        done,
    output logic        success,
    output logic [63:0] rdata,
    output logic [3:0]  pid,
    output logic [3:0]  endp,
    output logic [6:0]  addr,
    output logic [63:0] data,
    output logic        pkttype,
    output logic        pktready_bs,
    input  logic        down_ready,
    input  logic        sending_usb,
    input  logic [63:0] in_data,
    input  logic        in_pktready,
    input  logic        in_error,
    input  logic        in_ack,
    input  logic        in_nak,
    input  logic        inpipe_recving
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND_TOK  = 3'd1;
    localparam logic [2:0] SEND_DATA = 3'd2;
    localparam logic [2:0] WAIT_HS   = 3'd3;
    localparam logic [2:0] WAIT_DATA = 3'd4;
    localparam logic [2:0] SEND_ACK  = 3'd5;
    localparam logic [2:0] SEND_NAK  = 3'd6;
    localparam logic [2:0] FINISH    = 3'd7;

    localparam int RW = $clog2(MAX_RETRY + 1);

    logic [2:0]    state;
    logic [RW-1:0] retry_cnt;
    logic          launched;
    logic          seen;
    logic          result;
    logic          req_in;
    logic [6:0]    req_addr;
    logic [3:0]    req_endp;
    logic [63:0]   req_wdata;
    logic [63:0]   rbuf;
    logic          resp_eval;
    logic          take_data;
    logic          to_hit;
    logic [2:0]    fail_state;
    logic [3:0]    nxt_pid;
    logic          nxt_type;
    logic [63:0]   nxt_data;

    // A response is only trusted while the input pipe is idle or flags a finished packet.
    assign resp_eval  = !inpipe_recving || in_pktready || in_ack || in_nak;
    assign take_data  = (state == WAIT_DATA) && resp_eval && !in_nak && !in_error && in_pktready;
    assign fail_state = (retry_cnt == RW'(MAX_RETRY - 1)) ? FINISH : SEND_TOK;

`ifdef USB_TXN_TIMEOUT_EN
    logic [7:0] to_cnt;

    assign to_hit = (to_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            to_cnt <= '0;
        end else if (state == WAIT_HS || state == WAIT_DATA) begin
            to_cnt <= to_cnt + 8'd1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    // No timeout: the wait states hold until the pipe answers.
    assign to_hit = (TIMEOUT < 0);
`endif

    always_comb begin
        nxt_pid  = PID_OUT;
        nxt_type = 1'b0;
        nxt_data = '0;
        case (state)
            SEND_TOK:  nxt_pid = req_in ? PID_IN : PID_OUT;
            SEND_DATA: begin
                nxt_pid  = PID_DATA0;
                nxt_type = 1'b1;
                nxt_data = req_wdata;
            end
            SEND_ACK: begin
                nxt_pid  = PID_ACK;
                nxt_type = 1'b1;
            end
            SEND_NAK: begin
                nxt_pid  = PID_NAK;
                nxt_type = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            req_in    <= is_in;
            req_addr  <= txn_addr;
            req_endp  <= txn_endp;
            req_wdata <= wdata;
        end
        if (take_data) begin
            rbuf <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state       <= IDLE;
            retry_cnt   <= '0;
            launched    <= 1'b0;
            seen        <= 1'b0;
            result      <= 1'b0;
            done        <= 1'b0;
            success     <= 1'b0;
            rdata       <= '0;
            pid         <= '0;
            addr        <= '0;
            endp        <= '0;
            data        <= '0;
            pkttype     <= 1'b0;
            pktready_bs <= 1'b0;
        end else begin
            pktready_bs <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        retry_cnt <= '0;
                        result    <= 1'b0;
                        state     <= SEND_TOK;
                    end
                end
                WAIT_HS: begin
                    if (resp_eval && (in_nak || in_error)) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= fail_state;
                    end else if (resp_eval && in_ack) begin
                        result <= 1'b1;
                        state  <= FINISH;
                    end else if (to_hit) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= fail_state;
                    end
                end
                WAIT_DATA: begin
                    if (resp_eval && in_nak) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= fail_state;
                    end else if (resp_eval && in_error) begin
                        state <= SEND_NAK;
                    end else if (take_data) begin
                        state <= SEND_ACK;
                    end else if (to_hit) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= fail_state;
                    end
                end
                FINISH: begin
                    done    <= 1'b1;
                    success <= result;
                    state   <= IDLE;
                end
                default: begin
                    // Packet states: launch once, then wait for sending_usb to rise and fall.
                    if (!launched) begin
                        if (down_ready) begin
                            pktready_bs <= 1'b1;
                            pid         <= nxt_pid;
                            addr        <= req_addr;
                            endp        <= req_endp;
                            data        <= nxt_data;
                            pkttype     <= nxt_type;
                            launched    <= 1'b1;
                        end
                    end else if (!seen) begin
                        seen <= sending_usb;
                    end else if (!sending_usb) begin
                        launched <= 1'b0;
                        seen     <= 1'b0;
                        case (state)
                            SEND_TOK:  state <= req_in ? WAIT_DATA : SEND_DATA;
                            SEND_DATA: state <= WAIT_HS;
                            SEND_ACK: begin
                                result <= 1'b1;
                                rdata  <= rbuf;
                                state  <= FINISH;
                            end
                            default: begin
                                retry_cnt <= retry_cnt + 1'b1;
                                state     <= fail_state;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Directed bench for usb_txn_ctrl with a simple output-pipe model that logs every launched packet.
module tb_usb_txn_ctrl;

    logic        clk = 1'b0;
    logic        rst_L;
    logic        start;
    logic        is_in;
    logic [6:0]  txn_addr;
    logic [3:0]  txn_endp;
    logic [63:0] wdata;
    logic        done;
    logic        success;
    logic [63:0] rdata;
    logic [3:0]  pid;
    logic [3:0]  endp;
    logic [6:0]  addr;
    logic [63:0] data;
    logic        pkttype;
    logic        pktready_bs;
    logic        down_ready;
    logic        sending_usb;
    logic [63:0] in_data;
    logic        in_pktready;
    logic        in_error;
    logic        in_ack;
    logic        in_nak;
    logic        inpipe_recving;

    localparam logic [4:0] P_OUT   = 5'b0_0001;
    localparam logic [4:0] P_IN    = 5'b0_1001;
    localparam logic [4:0] P_DATA0 = 5'b1_0011;
    localparam logic [4:0] P_ACK   = 5'b1_0010;
    localparam logic [4:0] P_NAK   = 5'b1_1010;

    logic [4:0]  pkt_q[$];
    logic [63:0] pdat_q[$];
    logic [10:0] phdr_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    usb_txn_ctrl dut (
        .clk            (clk),
        .rst_L          (rst_L),
        .start          (start),
        .is_in          (is_in),
        .txn_addr       (txn_addr),
        .txn_endp       (txn_endp),
        .wdata          (wdata),
        .done           (done),
        .success        (success),
        .rdata          (rdata),
        .pid            (pid),
        .endp           (endp),
        .addr           (addr),
        .data           (data),
        .pkttype        (pkttype),
        .pktready_bs    (pktready_bs),
        .down_ready     (down_ready),
        .sending_usb    (sending_usb),
        .in_data        (in_data),
        .in_pktready    (in_pktready),
        .in_error       (in_error),
        .in_ack         (in_ack),
        .in_nak         (in_nak),
        .inpipe_recving (inpipe_recving)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Output pipe: accepts a launch, then stays busy for three cycles.
    initial begin
        sending_usb = 1'b0;
        down_ready  = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (pktready_bs === 1'b1) begin
                pkt_q.push_back({pkttype, pid});
                pdat_q.push_back(data);
                phdr_q.push_back({endp, addr});
                down_ready  = 1'b0;
                sending_usb = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                sending_usb = 1'b0;
                down_ready  = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        pkt_q.delete();
        pdat_q.delete();
        phdr_q.delete();
    endtask

    task automatic launch(input logic in_sel, input logic [63:0] wd);
        @(posedge clk); #1;
        start    = 1'b1;
        is_in    = in_sel;
        txn_addr = 7'h05;
        txn_endp = 4'h2;
        wdata    = wd;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_pkts(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (!(pkt_q.size() >= n && sending_usb == 1'b0) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, 64'(pkt_q.size() >= n), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic respond(input logic ack, input logic nak, input logic err, input logic rdy,
                           input logic [63:0] d);
        in_ack      = ack;
        in_nak      = nak;
        in_error    = err;
        in_pktready = rdy;
        in_data     = d;
        @(posedge clk); #1;
        in_ack      = 1'b0;
        in_nak      = 1'b0;
        in_error    = 1'b0;
        in_pktready = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic exp_succ);
        logic got;
        int   k;
        got = 1'b0;
        k   = 0;
        while (!got && k < 400) begin
            @(posedge clk); #1;
            k++;
            if (done === 1'b1) begin
                got = 1'b1;
                chk({tag, "_success"}, 64'(success), 64'(exp_succ));
            end
        end
        chk({tag, "_done"}, 64'(got), 64'd1);
    endtask

    initial begin
        rst_L = 1'b0; start = 1'b0; is_in = 1'b0; txn_addr = '0; txn_endp = '0; wdata = '0;
        in_data = '0; in_pktready = 1'b0; in_error = 1'b0; in_ack = 1'b0; in_nak = 1'b0;
        inpipe_recving = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_ctrl", 64'({done, success, pktready_bs, pkttype}), 64'd0);
        chk("rst_hdr", 64'({pid, addr, endp}), 64'd0);
        chk("rst_data", data, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        rst_L = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Successful OUT
        clear_log();
        launch(1'b0, 64'hDEADBEEFCAFEF00D);
        wait_pkts("out_pkts", 2, 200);
        respond(1'b1, 1'b0, 1'b0, 1'b0, '0);
        wait_done("out", 1'b1);
        @(posedge clk); #1;
        chk("out_done_pulse", 64'(done), 64'd0);
        chk("out_tok", 64'(pkt_q[0]), 64'(P_OUT));
        chk("out_tok_hdr", 64'(phdr_q[0]), 64'({4'h2, 7'h05}));
        chk("out_data_pid", 64'(pkt_q[1]), 64'(P_DATA0));
        chk("out_data", pdat_q[1], 64'hDEADBEEFCAFEF00D);
        chk("out_count", 64'(pkt_q.size()), 64'd2);

        // Successful IN
        clear_log();
        launch(1'b1, '0);
        wait_pkts("in_tok_sent", 1, 200);
        respond(1'b0, 1'b0, 1'b0, 1'b1, 64'h0123456789ABCDEF);
        wait_done("in", 1'b1);
        chk("in_tok", 64'(pkt_q[0]), 64'(P_IN));
        chk("in_ack_pkt", 64'(pkt_q[1]), 64'(P_ACK));
        chk("in_rdata", rdata, 64'h0123456789ABCDEF);

        // Retry exhaustion: eight NAKs
        clear_log();
        launch(1'b0, 64'h1111);
        for (int i = 0; i < 8; i++) begin
            wait_pkts("retry_pair", 2 * (i + 1), 200);
            respond(1'b0, 1'b1, 1'b0, 1'b0, '0);
        end
        wait_done("retry", 1'b0);
        chk("retry_count", 64'(pkt_q.size()), 64'd16);
        chk("retry_last_tok", 64'(pkt_q[14]), 64'(P_OUT));
        chk("retry_last_data", 64'(pkt_q[15]), 64'(P_DATA0));
        chk("retry_rdata_kept", rdata, 64'h0123456789ABCDEF);

        // IN error then good data
        clear_log();
        launch(1'b1, '0);
        wait_pkts("inerr_tok", 1, 200);
        respond(1'b0, 1'b0, 1'b1, 1'b0, '0);
        wait_pkts("inerr_retok", 3, 200);
        respond(1'b0, 1'b0, 1'b0, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0);
        wait_done("inerr", 1'b1);
        chk("inerr_nak", 64'(pkt_q[1]), 64'(P_NAK));
        chk("inerr_tok2", 64'(pkt_q[2]), 64'(P_IN));
        chk("inerr_ack", 64'(pkt_q[3]), 64'(P_ACK));
        chk("inerr_rdata", rdata, 64'hA5A5_5A5A_0F0F_F0F0);

        // ACK+NAK together is a NAK; start while busy is ignored
        clear_log();
        launch(1'b0, 64'h2222);
        wait_pkts("prio_pkts", 2, 200);
        start = 1'b1; is_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        respond(1'b1, 1'b1, 1'b0, 1'b0, '0);
        wait_pkts("prio_retry", 4, 200);
        respond(1'b1, 1'b0, 1'b0, 1'b0, '0);
        wait_done("prio", 1'b1);
        chk("prio_retok", 64'(pkt_q[2]), 64'(P_OUT));
        chk("prio_count", 64'(pkt_q.size()), 64'd4);

        // Error flagged while receiving is ignored
        clear_log();
        launch(1'b0, 64'h3333);
        wait_pkts("recv_pkts", 2, 200);
        inpipe_recving = 1'b1;
        respond(1'b0, 1'b0, 1'b1, 1'b0, '0);
        respond(1'b1, 1'b0, 1'b0, 1'b0, '0);
        inpipe_recving = 1'b0;
        wait_done("recv", 1'b1);
        chk("recv_count", 64'(pkt_q.size()), 64'd2);

        // No response
        clear_log();
        launch(1'b0, 64'h4444);
        wait_pkts("to_pkts", 2, 200);
        repeat (250) @(posedge clk);
        #1;
        chk("to_no_early", 64'(pkt_q.size()), 64'd2);
`ifdef USB_TXN_TIMEOUT_EN
        wait_pkts("to_retry", 4, 600);
        chk("to_retok", 64'(pkt_q[2]), 64'(P_OUT));
`endif
        respond(1'b1, 1'b0, 1'b0, 1'b0, '0);
        wait_done("to", 1'b1);

        // Reset in the middle of a packet
        clear_log();
        launch(1'b0, 64'hBEEF);
        for (int k = 0; k < 50 && sending_usb !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        chk("mid_busy", 64'(sending_usb), 64'd1);
        rst_L = 1'b0;
        #1;
        chk("mid_ctrl", 64'({done, success, pktready_bs, pkttype}), 64'd0);
        chk("mid_hdr", 64'({pid, addr, endp}), 64'd0);
        chk("mid_data", data, 64'd0);
        chk("mid_rdata", rdata, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_L = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        clear_log();
        launch(1'b0, 64'hDEADBEEFCAFEF00D);
        wait_pkts("post_pkts", 2, 200);
        respond(1'b1, 1'b0, 1'b0, 1'b0, '0);
        wait_done("post", 1'b1);
        chk("post_tok", 64'(pkt_q[0]), 64'(P_OUT));
        chk("post_data", pdat_q[1], 64'hDEADBEEFCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
